mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one combinational 4x4 `wallace_tree_multiplier` instance (ports A, B, product) between two requesters.
- Arbitrates requests, latches operands, and holds them stable for a programmable settle time.
- Registers the 8-bit product and returns it with the requester ID over a valid/ready response channel.
- Sits between the tile's request sources and the multiplier datapath.

Parameters:
- WAIT_CYCLES, 1, cycles operands are held on the multiplier before the product is sampled; legal range 1..15; 4-bit down-counter.
- OP_W, 4, operand width; only 4 supported, matching the multiplier; product width is 2*OP_W.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready
- req0_a  in  4  requester 0 operand A
- req0_b  in  4  requester 0 operand B
- req1_valid  in  1  requester 1 has an operation
- req1_ready  out  1  requester 1 accept
- req1_a  in  4  requester 1 operand A
- req1_b  in  4  requester 1 operand B
- rsp_valid  out  1  response held valid until rsp_ready
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the response (0/1)
- rsp_product  out  8  registered product
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE; op_a=op_b=0; wait counter=0.
  - rsp_valid=0, rsp_id=0, rsp_product=0, busy=0.
  - last_grant=1, so requester 0 wins the first tie.
- State IDLE:
  - req*_ready is combinational: asserted only for the granted requester, and only while in IDLE.
  - Grant when one valid only: that requester.
  - Grant when both valid: under round robin (see Optional Feature), the requester not equal to last_grant.
  - No valid: no ready, stay in IDLE.
  - On a handshake: latch op_a/op_b and the ID; set last_grant=ID; load counter=WAIT_CYCLES; go to WAIT.
- State WAIT:
  - op_a/op_b drive the multiplier A/B continuously; counter decrements each cycle.
  - On the cycle counter==1: register product into rsp_product, set rsp_valid=1, rsp_id=latched ID; go to RESP.
- State RESP:
  - rsp_valid, rsp_product and rsp_id are held stable while rsp_ready=0 (backpressure, unbounded).
  - On rsp_valid&rsp_ready: rsp_valid=0 next cycle; go to IDLE.
  - rsp_product keeps its last value after the handshake.
- Latency: accept at cycle T -> rsp_valid high at T+WAIT_CYCLES+1.
  - Minimum issue interval is WAIT_CYCLES+2 (rsp_ready tied high).
- Arithmetic: unsigned; product = op_a*op_b, 0..225, 8 bits; no truncation.
- Boundary conditions:
  - A requester dropping valid before grant loses nothing; no request is stored.
  - New requests arriving during WAIT or RESP see ready=0 and are never accepted.
  - Requester operand changes after accept do not affect the in-flight result.
  - rst_n asserted mid-operation: the in-flight operation is discarded, no response is produced, and last_grant returns to 1.
  - rsp_ready high outside RESP is ignored.

Optional Feature:
- MULT_RR_EN defined: round-robin tie-break using last_grant as above.
- MULT_RR_EN undefined: fixed priority, requester 0 always wins ties. last_grant is still tracked but unused.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Reset then req0 3x2, WAIT_CYCLES=1, rsp_ready=1 -> req0_ready pulse at T; rsp_valid at T+2 with product=6, id=0; busy high T+1..T+2.
- Both valid continuously (req0 5x3, req1 9x5), MULT_RR_EN defined -> responses alternate id 0 (15), 1 (45), 0, 1; no ready to the other requester while busy.
- Same stimulus, MULT_RR_EN undefined -> every response id=0, product=15; req1_ready never asserted.
- req1 15x15, rsp_ready=0 for 5 cycles after rsp_valid -> rsp_product=225, id=1 held stable; req0 ready stays 0; IDLE one cycle after rsp_ready=1.
- WAIT_CYCLES=4, req0 6x4 -> rsp_valid exactly 5 cycles after accept, product=24; changing req0_a during WAIT leaves result 24.
- rst_n pulsed low during WAIT -> rsp_valid never rises; busy=0; next tie grants requester 0 first.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Two-requester arbiter sharing one combinational 4x4 multiplier, with a
// valid/ready response channel. Define MULT_RR_EN for round-robin tie-break.
module wallace_tree_multiplier (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] product
);
  logic [7:0] pp [4];
  logic [7:0] s1, c1, s2, c2;

  // Carry-save reduction of the four partial-product rows, then one final add.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      pp[i] = {4'b0000, A & {4{B[i]}}} << i;
    end
    s1      = pp[0] ^ pp[1] ^ pp[2];
    c1      = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
    s2      = s1 ^ c1 ^ pp[3];
    c2      = ((s1 & c1) | (s1 & pp[3]) | (c1 & pp[3])) << 1;
    product = s2 + c2;
  end
endmodule

module mult_share_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned OP_W        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_a,
  input  logic [OP_W-1:0]   req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_a,
  input  logic [OP_W-1:0]   req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [2*OP_W-1:0] rsp_product,
  output logic              busy
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_e              state_q;
  logic [OP_W-1:0]     op_a_q, op_b_q;
  logic                id_q;
  logic                last_grant_q;
  logic [3:0]          cnt_q;
  logic                rsp_valid_q;
  logic                rsp_id_q;
  logic [2*OP_W-1:0]   rsp_product_q;
  logic                busy_q;

  logic                grant_vld_d;
  logic                grant_id_d;
  logic [OP_W-1:0]     op_a_d, op_b_d;
  logic [2*OP_W-1:0]   mult_p;

  wallace_tree_multiplier u_mult (
    .A       (op_a_q),
    .B       (op_b_q),
    .product (mult_p)
  );

  always_comb begin
    grant_vld_d = req0_valid | req1_valid;
    grant_id_d  = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef MULT_RR_EN
      grant_id_d = ~last_grant_q;
`else
      grant_id_d = 1'b0;
`endif
    end else if (req1_valid) begin
      grant_id_d = 1'b1;
    end
    op_a_d = grant_id_d ? req1_a : req0_a;
    op_b_d = grant_id_d ? req1_b : req0_b;
  end

`ifndef MULT_RR_EN
  // Fixed priority still tracks the last grant; it simply has no consumer.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
`endif

  assign req0_ready  = (state_q == ST_IDLE) && grant_vld_d && !grant_id_d;
  assign req1_ready  = (state_q == ST_IDLE) && grant_vld_d &&  grant_id_d;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;
  assign busy        = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      op_a_q        <= '0;
      op_b_q        <= '0;
      id_q          <= 1'b0;
      last_grant_q  <= 1'b1;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_product_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_vld_d) begin
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            id_q         <= grant_id_d;
            last_grant_q <= grant_id_d;
            cnt_q        <= WAIT_LD;
            busy_q       <= 1'b1;
            state_q      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            rsp_product_q <= mult_p;
            rsp_valid_q   <= 1'b1;
            rsp_id_q      <= id_q;
            state_q       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter; tie expectations follow MULT_RR_EN.
module tb_mult_share_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       r0v = 0, r1v = 0, rr = 0;
  logic [3:0] r0a = 0, r0b = 0, r1a = 0, r1b = 0;
  logic       rd0, rd1, rv, rid, bsy;
  logic [7:0] rp;

  logic       q0v = 0, q1v = 0, qr = 0;
  logic [3:0] q0a = 0, q0b = 0, q1a = 0, q1b = 0;
  logic       qrd0, qrd1, qrv, qid, qbsy;
  logic [7:0] qrp;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_id;

  always #5 clk = ~clk;

  mult_share_arbiter #(.WAIT_CYCLES(1), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_ready(rd0), .req0_a(r0a), .req0_b(r0b),
    .req1_valid(r1v), .req1_ready(rd1), .req1_a(r1a), .req1_b(r1b),
    .rsp_valid(rv), .rsp_ready(rr), .rsp_id(rid), .rsp_product(rp), .busy(bsy)
  );

  mult_share_arbiter #(.WAIT_CYCLES(4), .OP_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(q0v), .req0_ready(qrd0), .req0_a(q0a), .req0_b(q0b),
    .req1_valid(q1v), .req1_ready(qrd1), .req1_a(q1a), .req1_b(q1b),
    .rsp_valid(qrv), .rsp_ready(qr), .rsp_id(qid), .rsp_product(qrp), .busy(qbsy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(rv), 0);
    check("rst_busy", 32'(bsy), 0);
    check("rst_product", 32'(rp), 0);
    check("rst_id", 32'(rid), 0);
    check("rst_ready0", 32'(rd0), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request, WAIT_CYCLES=1
    r0v = 1; r0a = 4'd3; r0b = 4'd2; rr = 1;
    #1;
    check("t1_ready0", 32'(rd0), 1);
    check("t1_ready1", 32'(rd1), 0);
    check("t1_busy_T", 32'(bsy), 0);
    tick();
    r0v = 0;
    check("t1_busy_T1", 32'(bsy), 1);
    check("t1_valid_T1", 32'(rv), 0);
    check("t1_ready0_T1", 32'(rd0), 0);
    tick();
    check("t1_valid_T2", 32'(rv), 1);
    check("t1_product", 32'(rp), 6);
    check("t1_id", 32'(rid), 0);
    check("t1_busy_T2", 32'(bsy), 1);
    tick();
    check("t1_valid_T3", 32'(rv), 0);
    check("t1_busy_T3", 32'(bsy), 0);

    // Continuous tie between both requesters
    rst_n = 0; #2; rst_n = 1;
    r0v = 1; r0a = 4'd5; r0b = 4'd3;
    r1v = 1; r1a = 4'd9; r1b = 4'd5;
    exp_id = 1'b0;
    for (int r = 0; r < 4; r++) begin
      #1;
      check("tie_ready0", 32'(rd0), 32'(exp_id == 1'b0));
      check("tie_ready1", 32'(rd1), 32'(exp_id == 1'b1));
      check("tie_idle_busy", 32'(bsy), 0);
      tick();
      check("tie_wait_busy", 32'(bsy), 1);
      check("tie_wait_rdy", 32'({rd0, rd1}), 0);
      check("tie_wait_valid", 32'(rv), 0);
      tick();
      check("tie_rsp_valid", 32'(rv), 1);
      check("tie_rsp_id", 32'(rid), 32'(exp_id));
      check("tie_rsp_prod", 32'(rp), exp_id ? 32'd45 : 32'd15);
      check("tie_rsp_rdy", 32'({rd0, rd1}), 0);
`ifdef MULT_RR_EN
      exp_id = ~exp_id;
`endif
      tick();
    end
    r0v = 0; r1v = 0;

    // Backpressure on a 15x15 result from requester 1
    rr = 0;
    r1v = 1; r1a = 4'd15; r1b = 4'd15;
    #1;
    check("bp_ready1", 32'(rd1), 1);
    check("bp_ready0", 32'(rd0), 0);
    tick();
    r1v = 0; r0v = 1; r0a = 4'd1; r0b = 4'd1;
    #1;
    check("bp_wait_ready0", 32'(rd0), 0);
    check("bp_wait_busy", 32'(bsy), 1);
    tick();
    check("bp_valid", 32'(rv), 1);
    check("bp_product", 32'(rp), 225);
    check("bp_id", 32'(rid), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(rv), 1);
      check("bp_hold_prod", 32'(rp), 225);
      check("bp_hold_id", 32'(rid), 1);
      check("bp_hold_ready0", 32'(rd0), 0);
    end
    rr = 1;
    tick();
    check("bp_done_valid", 32'(rv), 0);
    check("bp_done_busy", 32'(bsy), 0);
    check("bp_keep_prod", 32'(rp), 225);
    check("bp_idle_ready0", 32'(rd0), 1);
    r0v = 0;
    #1;
    check("drop_ready0", 32'(rd0), 0);
    tick();
    check("drop_busy", 32'(bsy), 0);
    check("drop_valid", 32'(rv), 0);

    // WAIT_CYCLES=4 latency and operand isolation
    q0v = 1; q0a = 4'd6; q0b = 4'd4; qr = 1;
    #1;
    check("w4_ready0", 32'(qrd0), 1);
    tick();
    q0v = 0; q0a = 4'd15;
    for (int i = 1; i <= 4; i++) begin
      check("w4_not_yet", 32'(qrv), 0);
      tick();
    end
    check("w4_valid", 32'(qrv), 1);
    check("w4_product", 32'(qrp), 24);
    check("w4_id", 32'(qid), 0);
    tick();
    check("w4_done", 32'(qrv), 0);

    // Reset during WAIT discards the operation and restores last_grant
    r0v = 1; r0a = 4'd2; r0b = 4'd3;
    q0v = 1; q0a = 4'd2; q0b = 4'd3;
    #1;
    check("mr_ready0", 32'(rd0), 1);
    check("mr_q_ready0", 32'(qrd0), 1);
    tick();
    r0v = 0; q0v = 0;
    rst_n = 0;
    #1;
    check("mr_busy", 32'(bsy), 0);
    check("mr_valid", 32'(rv), 0);
    check("mr_q_busy", 32'(qbsy), 0);
    check("mr_q_valid", 32'(qrv), 0);
    #1 rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("mr_no_rsp", 32'(rv), 0);
      check("mr_q_no_rsp", 32'(qrv), 0);
    end
    r0v = 1; r0a = 4'd5; r0b = 4'd3;
    r1v = 1; r1a = 4'd9; r1b = 4'd5;
    #1;
    check("mr_tie_ready0", 32'(rd0), 1);
    check("mr_tie_ready1", 32'(rd1), 0);
    tick();
    r0v = 0; r1v = 0;
    tick();
    check("mr_tie_id", 32'(rid), 0);
    check("mr_tie_prod", 32'(rp), 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
